// File: rtl/alu_bus_pkg.sv
// Shared definitions for the shared-bus ALU and its bus sequencer: opcodes,
// sequencer state encoding and the opcode-support check.
package alu_bus_pkg;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_NOT  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    function automatic logic is_supported_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XNOR);
    endfunction

endpackage

// File: rtl/alu_bus_sequencer.sv
// Sequences one ALU op over the shared bus; accept-to-rsp_valid is 3+SETTLE (binary), 2+SETTLE (NOT), 1 (bad op).
// Backpressure: req_ready only in IDLE; result held in DONE until rsp_ready.
module alu_bus_sequencer
    import alu_bus_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             ALU_clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic [WIDTH-1:0] bus_data_o,
    output logic             bus_drive_en,
    input  logic [WIDTH-1:0] bus_data_i,
    output logic             alu_latch1_en,
    output logic             alu_latch2_en,
    output logic [3:0]       alu_control,
    output logic             alu_out_en,
    output logic             alu_reset
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    seq_state_t       state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       settle_cnt;

    always_ff @(posedge ALU_clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            settle_cnt <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q <= req_op;
                        a_q  <= req_a;
                        b_q  <= req_b;
                        if (is_supported_op(req_op)) begin
                            state <= ST_LOAD_A;
                        end else begin
                            // Rejected ops never touch the bus.
                            state      <= ST_DONE;
                            rsp_err    <= 1'b1;
                            rsp_result <= '0;
                        end
                    end
                end
                ST_LOAD_A: begin
                    settle_cnt <= '0;
                    state      <= (op_q == OP_NOT) ? ST_EXEC : ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    settle_cnt <= '0;
                    state      <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        rsp_result <= bus_data_i;
                        rsp_err    <= 1'b0;
                        state      <= ST_DONE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are forced low while reset is held, even before the state clears.
    always_comb begin
        bus_drive_en  = 1'b0;
        bus_data_o    = '0;
        alu_latch1_en = 1'b0;
        alu_latch2_en = 1'b0;
        alu_control   = '0;
        alu_out_en    = 1'b0;
        if (!reset) begin
            case (state)
                ST_LOAD_A: begin
                    bus_drive_en  = 1'b1;
                    bus_data_o    = a_q;
                    alu_latch1_en = 1'b1;
                end
                ST_LOAD_B: begin
                    bus_drive_en  = 1'b1;
                    bus_data_o    = b_q;
                    alu_latch2_en = 1'b1;
                end
                ST_EXEC: begin
                    alu_control = op_q;
                    alu_out_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = !reset && (state == ST_IDLE);
    assign rsp_valid = !reset && (state == ST_DONE);
    assign alu_reset = reset;

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// Closed-loop bench: sequencer + behavioural shared-bus ALU + bus resolver,
// checked every cycle against a transaction-level schedule model.
module tb_alu_bus_sequencer;
    import alu_bus_pkg::*;

    localparam int W = 16;
    localparam int S = 1;

    logic          ALU_clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [W-1:0]  req_a, req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_err;
    logic [W-1:0]  bus_data_o;
    logic          bus_drive_en;
    logic [W-1:0]  bus_data_i;
    logic          alu_latch1_en, alu_latch2_en;
    logic [3:0]    alu_control;
    logic          alu_out_en;
    logic          alu_reset;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;
    int strobe_cnt = 0;
    int latch2_cnt = 0;

    always #5 ALU_clock = ~ALU_clock;

    alu_bus_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .ALU_clock(ALU_clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .bus_data_o(bus_data_o), .bus_drive_en(bus_drive_en), .bus_data_i(bus_data_i),
        .alu_latch1_en(alu_latch1_en), .alu_latch2_en(alu_latch2_en),
        .alu_control(alu_control), .alu_out_en(alu_out_en), .alu_reset(alu_reset)
    );

    function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_NOT:  return ~a;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_XNOR: return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    // Shared-bus ALU and bus resolver
    logic [W-1:0] l1 = '0, l2 = '0;
    logic [W-1:0] alu_y;
    always @(posedge ALU_clock) begin
        if (alu_reset) begin
            l1 <= '0;
            l2 <= '0;
        end else begin
            if (alu_latch1_en) l1 <= bus_data_i;
            if (alu_latch2_en) l2 <= bus_data_i;
        end
    end
    assign alu_y      = alu_out_en ? alu_fn(alu_control, l1, l2) : '0;
    assign bus_data_i = bus_drive_en ? bus_data_o : alu_y;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: an op occupies the bus for its load cycles, then
    // the ALU for S cycles, then waits in a response slot until taken.
    bit           m_busy = 1'b0, m_done = 1'b0;
    int           m_age = 0;
    logic [3:0]   m_op = '0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic         m_err = 1'b0;

    function automatic int nload();
        return (m_op == OP_NOT) ? 1 : 2;
    endfunction

    always @(posedge ALU_clock) begin
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_err = 1'b0;
        end else if (m_done) begin
            if (rsp_ready) m_done = 1'b0;
        end else if (m_busy) begin
            m_age++;
            if (m_age > nload() + S) begin
                m_busy = 1'b0; m_done = 1'b1;
                m_res = alu_fn(m_op, m_a, m_b); m_err = 1'b0;
            end
        end else if (req_valid) begin
            m_op = req_op; m_a = req_a; m_b = req_b;
            if (req_op >= 4'd1 && req_op <= 4'd7) begin
                m_busy = 1'b1; m_age = 1;
            end else begin
                m_done = 1'b1; m_err = 1'b1; m_res = '0;
            end
        end
    end

    always @(negedge ALU_clock) begin : compare
        logic e_ld, e_ex;
        logic [W-1:0] e_data;
        if (cmp_en) begin
            e_ld   = !reset && m_busy && (m_age <= nload());
            e_ex   = !reset && m_busy && (m_age >  nload());
            e_data = !e_ld ? '0 : (m_age == 1 ? m_a : m_b);
            chk("req_ready",  32'(req_ready),     32'(!reset && !m_busy && !m_done));
            chk("rsp_valid",  32'(rsp_valid),     32'(!reset && m_done));
            chk("rsp_result", 32'(rsp_result),    32'(m_res));
            chk("rsp_err",    32'(rsp_err),       32'(m_err));
            chk("drive_en",   32'(bus_drive_en),  32'(e_ld));
            chk("bus_data_o", 32'(bus_data_o),    32'(e_data));
            chk("latch1",     32'(alu_latch1_en), 32'(e_ld && m_age == 1));
            chk("latch2",     32'(alu_latch2_en), 32'(e_ld && m_age == 2));
            chk("alu_ctl",    32'(alu_control),   e_ex ? 32'(m_op) : 32'd0);
            chk("alu_out_en", 32'(alu_out_en),    32'(e_ex));
            chk("alu_reset",  32'(alu_reset),     32'(reset));
            chk("bus_contention", 32'(bus_drive_en && alu_out_en), 32'd0);
            chk("latch_overlap",  32'(alu_latch1_en && alu_latch2_en), 32'd0);
            if (bus_drive_en || alu_out_en || alu_latch1_en || alu_latch2_en) strobe_cnt++;
            if (alu_latch2_en) latch2_cnt++;
        end
    end

    task automatic tick();
        @(posedge ALU_clock);
        #2;
    endtask

    task automatic wait_rsp(input string nm, input logic [W-1:0] er, input logic ee, input int elat);
        int lat = 1;
        while (!rsp_valid && lat < 64) begin
            tick();
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_result"},  32'(rsp_result), 32'(er));
        chk({nm, "_err"},     32'(rsp_err), 32'(ee));
    endtask

    // Presents one request, waits for the result; completes the handshake if rsp_ready.
    task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ee, input int elat);
        int g = 0;
        while (!req_ready && g < 64) begin
            tick();
            g++;
        end
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_rsp(nm, er, ee, elat);
        if (rsp_ready) tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int s0, l0, g;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        @(posedge ALU_clock);
        #2;
        cmp_en = 1'b1;
        tick();
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_result",    32'(rsp_result), 32'd0);
        chk("reset_err",       32'(rsp_err), 32'd0);
        chk("reset_alu_reset", 32'(alu_reset), 32'd1);
        reset = 1'b0;
        #1;
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        run_op("add",  OP_ADD,  16'h1234, 16'h0FCC, 16'h2200, 1'b0, 4);
        run_op("sub",  OP_SUB,  16'h0005, 16'h0007, 16'hFFFE, 1'b0, 4);
        run_op("xnor", OP_XNOR, 16'hF0F0, 16'hFF00, 16'hF00F, 1'b0, 4);

        l0 = latch2_cnt;
        run_op("not",  OP_NOT,  16'h00FF, 16'hAAAA, 16'hFF00, 1'b0, 3);
        chk("not_no_latch2", 32'(latch2_cnt - l0), 32'd0);

        s0 = strobe_cnt;
        run_op("badop", 4'h9, 16'h5555, 16'h3333, 16'h0000, 1'b1, 1);
        chk("badop_no_strobes", 32'(strobe_cnt - s0), 32'd0);

        // Backpressured response with a second request already waiting.
        rsp_ready = 1'b0;
        run_op("and", OP_AND, 16'h3C3C, 16'h0FF0, 16'h0C30, 1'b0, 4);
        req_op = OP_XOR; req_a = 16'h00FF; req_b = 16'h0F0F; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid",  32'(rsp_valid), 32'd1);
            chk("hold_result", 32'(rsp_result), 32'h0C30);
            chk("hold_ready",  32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("after_hs_valid", 32'(rsp_valid), 32'd0);
        chk("after_hs_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        wait_rsp("xor2", 16'h0FF0, 1'b0, 4);
        tick();

        // Reset while the ALU is driving its result.
        req_op = OP_ADD; req_a = 16'h1111; req_b = 16'h2222; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        g = 0;
        while (!alu_out_en && g < 20) begin
            tick();
            g++;
        end
        chk("rst_reached_exec", 32'(alu_out_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_gates_out_en", 32'(alu_out_en), 32'd0);
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_reset", 32'(alu_reset), 32'd1);
        chk("rst_strobes", 32'({bus_drive_en, alu_out_en, alu_latch1_en, alu_latch2_en}), 32'd0);
        chk("rst_result_cleared", 32'(rsp_result), 32'd0);
        chk("rst_alu_latch_clear", 32'(l1), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_idle_ready", 32'(req_ready), 32'd1);
        run_op("or", OP_OR, 16'h0001, 16'h8000, 16'h8001, 1'b0, 4);

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
